// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory port, redirect input, decode handshake and status of the fetch stage.
interface instr_fetch_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
    logic [63:0] fault_addr;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, fault, fault_addr, fetch_count,
        input  imem_instr, redirect_valid, redirect_target, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, fault, fault_addr, fetch_count,
        output imem_instr, redirect_valid, redirect_target, out_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and one-entry fetch register in front of decode.
// Faults stickily on misaligned or out-of-range fetch addresses instead of reading them.
module instr_fetch #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input logic         clk,
    input logic         reset,
    instr_fetch_if.master bus
);
    typedef enum logic {RUN, FAULT} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] opc_q, opc_d;
    logic        fault_q, fault_d;
    logic [63:0] faddr_q, faddr_d;
    logic [31:0] cnt_q, cnt_d;
    logic        slot_free;

    // 65-bit sum so addresses near 2^64 cannot wrap past the bound check
    function automatic logic bad(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (({1'b0, a} + 65'd3) >= 65'(MEM_SIZE));
    endfunction

    assign slot_free = !valid_q || bus.out_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        fault_d = fault_q;
        faddr_d = faddr_q;
        cnt_d   = cnt_q + 32'((valid_q && bus.out_ready && !bus.redirect_valid) ? 1 : 0);
        if (state_q == FAULT) begin
            valid_d = 1'b0;
        end else if (bus.redirect_valid) begin
            valid_d = 1'b0;
            if (bad(bus.redirect_target)) begin
                state_d = FAULT;
                fault_d = 1'b1;
                faddr_d = bus.redirect_target;
            end else begin
                pc_d = bus.redirect_target;
            end
        end else if (slot_free && bad(pc_q)) begin
            state_d = FAULT;
            fault_d = 1'b1;
            faddr_d = pc_q;
            valid_d = 1'b0;
        end else if (slot_free) begin
            instr_d = bus.imem_instr;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 64'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            opc_q   <= 64'd0;
            fault_q <= 1'b0;
            faddr_q <= 64'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            fault_q <= fault_d;
            faddr_q <= faddr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_instr   = instr_q;
    assign bus.out_pc      = opc_q;
    assign bus.fault       = fault_q;
    assign bus.fault_addr  = faddr_q;
    assign bus.fetch_count = cnt_q;
endmodule
